// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: accepts one CPU load/store at a time, checks
// legality, issues a single-cycle memory strobe and returns an extended response.
module dm_access_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_we,
    output logic        dm_re,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    output logic [2:0]  dm_wop,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;

    logic [31:0] r_holdAddr;
    logic [31:0] r_holdWdata;
    logic [31:0] r_holdPc;
    logic [2:0]  r_holdWop;

    logic [31:0] r_respRdata;
    logic        r_respErr;

    logic        w_illegal;
    logic        w_inAcc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_illegal = (req_op[1:0] == 2'b11)
                     || ((req_op[1:0] == 2'b00) && (req_addr[1:0] != 2'b00))
                     || ((req_op[1:0] == 2'b10) && req_addr[0])
                     || (req_addr >= ADDR_LIMIT);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_nextState = w_illegal ? RESP : ACC;
            ACC:     w_nextState = RESP;
            RESP:    if (resp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Strobes are gated by reset so a store caught mid-ACC never writes memory.
    assign w_inAcc    = (r_state == ACC);
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign dm_we      = w_inAcc && r_we && !reset;
    assign dm_re      = w_inAcc && !r_we && !reset;
    assign dm_addr    = w_inAcc ? r_addr : r_holdAddr;
    assign dm_wdata   = w_inAcc ? r_wdata : r_holdWdata;
    assign dm_pc      = w_inAcc ? r_pc : r_holdPc;
    assign dm_wop     = w_inAcc ? {1'b0, r_op[1:0]} : r_holdWop;
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;

    always_comb begin
        w_byte = dm_rdata[7:0];
        case (r_addr[1:0])
            2'b00: w_byte = dm_rdata[7:0];
            2'b01: w_byte = dm_rdata[15:8];
            2'b10: w_byte = dm_rdata[23:16];
            2'b11: w_byte = dm_rdata[31:24];
            default: w_byte = dm_rdata[7:0];
        endcase
        w_half = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_op[1:0])
            2'b00:   w_load = dm_rdata;
            2'b01:   w_load = r_op[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b10:   w_load = r_op[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_op        <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_pc        <= 32'h0;
            r_holdAddr  <= 32'h0;
            r_holdWdata <= 32'h0;
            r_holdPc    <= 32'h0;
            r_holdWop   <= 3'b000;
            r_respRdata <= 32'h0;
            r_respErr   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == IDLE) && req_valid) begin
                r_we    <= req_we;
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
                if (w_illegal) begin
                    r_respRdata <= 32'h0;
                    r_respErr   <= 1'b1;
                end
            end
            // The memory-side outputs keep the last issued access once ACC ends.
            if (w_inAcc) begin
                r_holdAddr  <= r_addr;
                r_holdWdata <= r_wdata;
                r_holdPc    <= r_pc;
                r_holdWop   <= {1'b0, r_op[1:0]};
                r_respRdata <= r_we ? 32'h0 : w_load;
                r_respErr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed vector table, corner sequences
// and randomized traffic checked against a byte-array memory model.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_pc;
    logic [2:0]  dm_wop;
    logic [31:0] dm_rdata;

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;
    int weCount = 0;
    int reCount = 0;

    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic [7:0]  refMem [0:12287] = '{default: 8'h0};

    logic [31:0] sAddr;
    logic [31:0] sWdata;
    logic [31:0] sPc;
    logic [2:0]  sWop;

    always #5 clk = ~clk;

    dm_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_pc(dm_pc), .dm_wop(dm_wop), .dm_rdata(dm_rdata)
    );

    // Word-wide data memory with byte/half write lanes selected by dm_wop.
    assign dm_rdata = dm_re ? mem[dm_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (dm_we) begin
            weCount <= weCount + 1;
            case (dm_wop)
                3'b000: mem[dm_addr[13:2]] <= dm_wdata;
                3'b001: mem[dm_addr[13:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_wdata[7:0];
                3'b010: mem[dm_addr[13:2]][{dm_addr[1], 4'b0000} +: 16] <= dm_wdata[15:0];
                default: ;
            endcase
        end
        if (dm_re) reCount <= reCount + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: byte-addressed memory, illegal checks and extension by arithmetic.
    task automatic refApply(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] expR, output logic expE);
        int nBytes;
        longint value;
        bit bad;
        nBytes = (op[1:0] == 2'b00) ? 4 : (op[1:0] == 2'b01) ? 1 : 2;
        bad = (op[1:0] == 2'b11) || (addr >= 32'h3000) || ((addr % nBytes) != 0);
        expR = 32'h0;
        expE = bad;
        if (!bad) begin
            if (we) begin
                for (int k = 0; k < nBytes; k++) refMem[addr + k] = wdata[8*k +: 8];
            end else begin
                value = 0;
                for (int k = 0; k < nBytes; k++) value = value + (longint'(refMem[addr + k]) << (8 * k));
                if (nBytes < 4 && !op[2] && value >= (longint'(1) << (8 * nBytes - 1)))
                    value = value - (longint'(1) << (8 * nBytes));
                expR = value[31:0];
            end
        end
    endtask

    // Issue one request from IDLE, wait for the response, optionally stall, then release it.
    task automatic applyStimulus(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pc, input int waitCycles,
                                 output logic [31:0] rdata, output logic err, output int latency);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
        @(negedge clk);
        req_valid = 1'b0;
        latency = 1;
        while (!resp_valid && latency < 10) begin
            if (dm_we || dm_re) begin
                sAddr = dm_addr; sWdata = dm_wdata; sPc = dm_pc; sWop = dm_wop;
            end
            @(negedge clk);
            latency++;
        end
        if (!resp_valid) begin
            failed++; tests++;
            $display("[TB] FAIL respTimeout: resp_valid=0 after %0d cycles, required 1", latency);
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int w = 0; w < waitCycles; w++) begin
            @(negedge clk);
            checkOutput("holdValid", {31'h0, resp_valid}, 32'h1);
            checkOutput("holdReqReady", {31'h0, req_ready}, 32'h0);
            checkOutput("holdRdata", resp_rdata, rdata);
            checkOutput("holdErr", {31'h0, resp_err}, {31'h0, err});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] rdata, expR;
        logic        err, expE;
        int          latency, weBefore, reBefore, lastT, nWait, nResp;
        logic        b2bWe [5];
        logic [2:0]  b2bOp [5];
        logic [31:0] b2bAddr [5];
        logic [31:0] b2bExpR [5];
        logic        b2bExpE [5];

        vecs[0]  = '{1'b1, 3'b000, 32'h10,   32'hDEADBEEF, 32'h3000, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 3'b000, 32'h20,   32'h80FF7F01, 32'h3004, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 3'b001, 32'h23,   32'h0,        32'h3008, 32'hFFFFFF80, 1'b0};
        vecs[3]  = '{1'b0, 3'b101, 32'h23,   32'h0,        32'h300C, 32'h00000080, 1'b0};
        vecs[4]  = '{1'b0, 3'b010, 32'h20,   32'h0,        32'h3010, 32'h00007F01, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 32'h22,   32'h0,        32'h3014, 32'hFFFF80FF, 1'b0};
        vecs[6]  = '{1'b0, 3'b110, 32'h22,   32'h0,        32'h3018, 32'h000080FF, 1'b0};
        vecs[7]  = '{1'b0, 3'b000, 32'h22,   32'h0,        32'h301C, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 3'b010, 32'h3000, 32'h1234,     32'h3020, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 3'b011, 32'h24,   32'h0,        32'h3024, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 3'b001, 32'h11,   32'h123456AA, 32'h3028, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 3'b110, 32'h12,   32'hFFFF1234, 32'h302C, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 3'b000, 32'h10,   32'h0,        32'h3030, 32'h1234AAEF, 1'b0};
        vecs[13] = '{1'b0, 3'b000, 32'h2FFC, 32'h0,        32'h3034, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 3'b001, 32'h3000, 32'h0,        32'h3038, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 3'b010, 32'h21,   32'h0,        32'h303C, 32'h0,        1'b1};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rstReqReady", {31'h0, req_ready}, 32'h1);
        checkOutput("rstRespValid", {31'h0, resp_valid}, 32'h0);
        checkOutput("rstRdata", resp_rdata, 32'h0);
        checkOutput("rstErr", {31'h0, resp_err}, 32'h0);
        checkOutput("rstStrobes", {30'h0, dm_we, dm_re}, 32'h0);
        checkOutput("rstDmAddr", dm_addr, 32'h0);
        checkOutput("rstDmWdata", dm_wdata, 32'h0);
        checkOutput("rstDmPc", dm_pc, 32'h0);
        checkOutput("rstDmWop", {29'h0, dm_wop}, 32'h0);

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            weBefore = weCount; reBefore = reCount;
            applyStimulus(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pc, 0,
                          rdata, err, latency);
            refApply(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, expR, expE);
            checkOutput($sformatf("vec%0dRdata", i), rdata, vecs[i].expRdata);
            checkOutput($sformatf("vec%0dErr", i), {31'h0, err}, {31'h0, vecs[i].expErr});
            checkOutput($sformatf("vec%0dLatency", i), 32'(latency), vecs[i].expErr ? 32'd1 : 32'd2);
            checkOutput($sformatf("vec%0dWeCount", i), 32'(weCount - weBefore),
                        (vecs[i].we && !vecs[i].expErr) ? 32'd1 : 32'd0);
            checkOutput($sformatf("vec%0dReCount", i), 32'(reCount - reBefore),
                        (!vecs[i].we && !vecs[i].expErr) ? 32'd1 : 32'd0);
            if (!vecs[i].expErr) begin
                checkOutput($sformatf("vec%0dDmAddr", i), sAddr, vecs[i].addr);
                checkOutput($sformatf("vec%0dDmWop", i), {29'h0, sWop}, {30'h0, vecs[i].op[1:0]});
                checkOutput($sformatf("vec%0dDmWdata", i), sWdata, vecs[i].wdata);
                checkOutput($sformatf("vec%0dDmPc", i), sPc, vecs[i].pc);
            end
        end

        // Response stalled for five cycles must stay stable.
        applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 32'h4000, 5, rdata, err, latency);
        checkOutput("stallRdata", rdata, 32'hFFFF80FF);
        checkOutput("stallDmAddrHeld", dm_addr, 32'h20 + 32'h2);

        // Reset asserted during the ACC cycle of a byte store.
        weBefore = weCount;
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b001; req_addr = 32'h30;
        req_wdata = 32'h55; req_pc = 32'h5000;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("accRstDmWe", {31'h0, dm_we}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("accRstWeCount", 32'(weCount - weBefore), 32'd0);
        checkOutput("accRstReqReady", {31'h0, req_ready}, 32'h1);
        checkOutput("accRstRespValid", {31'h0, resp_valid}, 32'h0);
        checkOutput("accRstRdata", resp_rdata, 32'h0);
        checkOutput("accRstErr", {31'h0, resp_err}, 32'h0);
        checkOutput("accRstDmAddr", dm_addr, 32'h0);
        checkOutput("accRstDmWdata", dm_wdata, 32'h0);
        checkOutput("accRstDmPc", dm_pc, 32'h0);
        checkOutput("accRstDmWop", {29'h0, dm_wop}, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h30, 32'h0, 32'h5004, 0, rdata, err, latency);
        checkOutput("accRstMemUntouched", rdata, 32'h0);

        // Back-to-back traffic with resp_ready tied high.
        b2bWe[0] = 1'b0; b2bOp[0] = 3'b000; b2bAddr[0] = 32'h10;
        b2bWe[1] = 1'b0; b2bOp[1] = 3'b000; b2bAddr[1] = 32'h11;
        b2bWe[2] = 1'b1; b2bOp[2] = 3'b000; b2bAddr[2] = 32'h40;
        b2bWe[3] = 1'b0; b2bOp[3] = 3'b011; b2bAddr[3] = 32'h40;
        b2bWe[4] = 1'b0; b2bOp[4] = 3'b000; b2bAddr[4] = 32'h40;
        resp_ready = 1'b1;
        lastT = 0;
        for (int i = 0; i < 5; i++) begin
            refApply(b2bWe[i], b2bOp[i], b2bAddr[i], 32'hCAFE0000 + 32'(i), b2bExpR[i], b2bExpE[i]);
            if (i > 0)
                checkOutput($sformatf("b2bSpacing%0d", i), 32'(cycle - lastT), b2bExpE[i-1] ? 32'd2 : 32'd3);
            lastT = cycle;
            req_valid = 1'b1; req_we = b2bWe[i]; req_op = b2bOp[i]; req_addr = b2bAddr[i];
            req_wdata = 32'hCAFE0000 + 32'(i); req_pc = 32'h6000 + 32'(4 * i);
            nWait = 0; nResp = 0;
            do begin
                @(negedge clk);
                nWait++;
                if (resp_valid) begin
                    nResp++;
                    checkOutput($sformatf("b2bRdata%0d", i), resp_rdata, b2bExpR[i]);
                    checkOutput($sformatf("b2bErr%0d", i), {31'h0, resp_err}, {31'h0, b2bExpE[i]});
                end
            end while (!req_ready && nWait < 10);
            checkOutput($sformatf("b2bRespCount%0d", i), 32'(nResp), 32'd1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic        rWe;
            logic [2:0]  rOp;
            logic [31:0] rAddr, rWdata;
            rWe    = 1'($urandom_range(0, 1));
            rOp    = 3'($urandom_range(0, 7));
            rAddr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(32'h2FF0, 32'h300F))
                                                 : 32'($urandom_range(0, 32'h7F));
            rWdata = $urandom;
            refApply(rWe, rOp, rAddr, rWdata, expR, expE);
            applyStimulus(rWe, rOp, rAddr, rWdata, $urandom, $urandom_range(0, 2), rdata, err, latency);
            checkOutput($sformatf("rnd%0dRdata", n), rdata, expR);
            checkOutput($sformatf("rnd%0dErr", n), {31'h0, err}, {31'h0, expE});
            checkOutput($sformatf("rnd%0dLatency", n), 32'(latency), expE ? 32'd1 : 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
